// File: rtl/ls_sequencer.sv
// -----------------------------------------------------------------------------
// ls_sequencer
// Multi-cycle controller that executes one RISC-V LD or SD at a time against a
// 32x64 register bank (registered read ports) and a data memory.
//
// Flow: IDLE -> READ -> ADDR -> MEM -> (WB for loads) -> IDLE
//
// Ports
//   clk, rst         clock / synchronous active-high reset
//   instr_valid      instr holds a valid instruction
//   instr            32-bit RISC-V instruction word
//   instr_ready      high only in IDLE; the instruction is taken on valid&ready
//   Ra, Rb, Rw       bank read address A (rs1), B (rs2 for SD), write address
//   WE_Reg           one-cycle bank write enable (suppressed when rd == x0)
//   doutA, doutB     bank read data, one cycle after Ra/Rb change
//   mem_addr         effective address doutA + imm (wraps modulo 2^DATA_W)
//   mem_wdata        store data
//   mem_re, mem_we   memory request, held until mem_ready or timeout
//   mem_ready        memory completed the request this cycle
//   done             one-cycle pulse when the instruction retires
//   err              one-cycle pulse on illegal encoding or memory timeout
// -----------------------------------------------------------------------------
module ls_sequencer #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [4:0]        Ra,
    output logic [4:0]        Rb,
    output logic [4:0]        Rw,
    output logic              WE_Reg,
    input  logic [DATA_W-1:0] doutA,
    input  logic [DATA_W-1:0] doutB,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ADDR,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic                is_sd_q, is_sd_d;
    logic [11:0]         imm_q, imm_d;
    logic [4:0]          rd_q, rd_d;
    logic [4:0]          ra_q, ra_d;
    logic [4:0]          rb_q, rb_d;
    logic [4:0]          rw_q, rw_d;
    logic                we_reg_q, we_reg_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [7:0]          timer_q, timer_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Decode of the incoming word (only used while in IDLE)
    logic        dec_ld, dec_sd;
    logic [11:0] dec_imm;
    logic [7:0]  timer_inc;
    logic [DATA_W-1:0] imm_ext;

    assign dec_ld  = (instr[6:0] == 7'b0000011) && (instr[14:12] == 3'b011);
    assign dec_sd  = (instr[6:0] == 7'b0100011) && (instr[14:12] == 3'b011);
    // S-type splits the immediate around the rd field; I-type keeps it whole
    assign dec_imm = dec_sd ? {instr[31:25], instr[11:7]} : instr[31:20];

    assign imm_ext   = {{(DATA_W-12){imm_q[11]}}, imm_q};
    assign timer_inc = timer_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        is_sd_d  = is_sd_q;
        imm_d    = imm_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rw_d     = rw_q;
        we_reg_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        re_d     = re_q;
        we_d     = we_q;
        timer_d  = timer_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (dec_ld || dec_sd) begin
                        is_sd_d = dec_sd;
                        imm_d   = dec_imm;
                        rd_d    = instr[11:7];
                        ra_d    = instr[19:15];
                        rb_d    = dec_sd ? instr[24:20] : 5'd0;
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            // Bank outputs are registered: Ra/Rb changed on the accept edge,
            // so doutA/doutB become valid one cycle later.
            S_READ: state_d = S_ADDR;

            S_ADDR: begin
                addr_d  = doutA + imm_ext;
                timer_d = 8'd0;
                if (is_sd_q) begin
                    wdata_d = doutB;
                    we_d    = 1'b1;
                end else begin
                    re_d = 1'b1;
                end
                state_d = S_MEM;
            end

            S_MEM: begin
                if (mem_ready) begin
                    re_d = 1'b0;
                    we_d = 1'b0;
                    if (is_sd_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Load data goes straight from memory into the bank
                        rw_d     = rd_q;
                        we_reg_d = (rd_q != 5'd0);
                        state_d  = S_WB;
                    end
                end else if (timer_inc == TIMEOUT_C) begin
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    timer_d = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            S_WB: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            is_sd_q  <= 1'b0;
            imm_q    <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rw_q     <= '0;
            we_reg_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_sd_q  <= is_sd_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rw_q     <= rw_d;
            we_reg_q <= we_reg_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            re_q     <= re_d;
            we_q     <= we_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign Ra          = ra_q;
    assign Rb          = rb_q;
    assign Rw          = rw_q;
    assign WE_Reg      = we_reg_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_re      = re_q;
    assign mem_we      = we_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/ls_sequencer.md
Name: ls_sequencer

Overview:
- Multi-cycle controller that executes one RISC-V LD or SD instruction at a time against the 32x64 register bank and the data memory.
- Decodes the instruction and drives the bank's Ra/Rb/Rw/WE_Reg.
- Computes the effective address from doutA plus the immediate, issues the memory request, waits for completion and writes load data back to the bank.
- Sits between the instruction source (valid/ready handshake) and the register-bank/memory pair.

Parameters:
DATA_W, 64, register/memory data width
TIMEOUT, 255, max cycles waiting for mem_ready before aborting (8-bit counter)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  instr holds a valid instruction
instr  input  32  RISC-V instruction word
instr_ready  output  1  sequencer accepts instr this cycle
Ra  output  5  bank read address A (base register rs1)
Rb  output  5  bank read address B (store data register rs2)
Rw  output  5  bank write address (rd)
WE_Reg  output  1  bank write enable, one-cycle pulse
doutA  input  DATA_W  bank read data A (registered, 1-cycle latency)
doutB  input  DATA_W  bank read data B (registered, 1-cycle latency)
mem_addr  output  DATA_W  effective address
mem_wdata  output  DATA_W  store data
mem_re  output  1  memory read request, held until mem_ready
mem_we  output  1  memory write request, held until mem_ready
mem_ready  input  1  memory completed the request this cycle
done  output  1  one-cycle pulse, instruction retired
err  output  1  one-cycle pulse, illegal opcode/funct3 or timeout

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; all outputs 0, including Ra/Rb/Rw/addresses and the timeout counter. Reset mid-operation aborts immediately: no WE_Reg, and mem_re/mem_we drop the next cycle.
- Accepted encodings:
  - LD: opcode 0000011, funct3 011; imm = sign-extended instr[31:20].
  - SD: opcode 0100011, funct3 011; imm = sign-extended {instr[31:25], instr[11:7]}.
  - Anything else is illegal.
- Fields: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- FSM states and transitions:
  - IDLE: instr_ready=1. On instr_valid, latch the instruction. If illegal, pulse err next cycle and stay in IDLE. If legal, set Ra=rs1, Rb=rs2 (SD) or 0 (LD), then go to READ.
  - READ: wait one cycle for the bank's registered outputs; go to ADDR.
  - ADDR: mem_addr = doutA + imm (DATA_W-bit, wraps modulo 2^64, no overflow flag). For SD, mem_wdata = doutB. Assert mem_re (LD) or mem_we (SD) from the next cycle; go to MEM.
  - MEM: hold mem_addr, mem_wdata and the request until the cycle mem_ready=1.
    - LD: capture nothing (the bank takes dIN directly from memory), go to WB.
    - SD: drop mem_we the next cycle, pulse done, go to IDLE.
    - Counter increments each waiting cycle. When it reaches TIMEOUT without mem_ready: drop the request, pulse err, go to IDLE.
  - WB: Rw=rd, WE_Reg=1 for exactly one cycle unless rd==0 (write suppressed, x0 stays 0). Pulse done, go to IDLE.
- instr_ready is 0 in every state except IDLE; instr is ignored while instr_ready=0.
- mem_re and mem_we are never both 1.
- Latency from accept to done with mem_ready at the first request cycle:
  - SD: 4 cycles.
  - LD: 5 cycles.
- Back-to-back: a new instruction can be accepted in the cycle the sequencer returns to IDLE.
- Ra, Rb and Rw hold their last values in IDLE; WE_Reg=0 except in WB.

Test Plan:
1. Reset, then LD x5, 16(x2) with doutA=0x1000 and mem_ready on the first cycle -> mem_addr=0x1010, mem_re=1 for 1 cycle, WE_Reg=1 with Rw=5 once, done 5 cycles after accept.
2. SD x7, -8(x3) with doutA=0x2000, doutB=0xDEADBEEF -> mem_addr=0x1FF8, mem_wdata=0xDEADBEEF, mem_we held through 3 cycles of mem_ready=0, WE_Reg never asserted, done once.
3. LD with rd=x0 -> memory read occurs, WE_Reg stays 0, done pulses.
4. Illegal word 0x00000013 (ADDI) -> err pulse, no mem_re/mem_we, instr_ready back to 1 next cycle.
5. mem_ready held 0 with TIMEOUT=4 -> request drops after 4 wait cycles, err=1, no writeback.
6. rst asserted in MEM of an LD, and separately doutA=0xFFFFFFFFFFFFFFF8 with imm=16 -> first: all outputs 0 next cycle and no WE_Reg; second: mem_addr=0x8 (wrap-around).
